// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: active-high segment
// patterns ({g,f,e,d,c,b,a}), the slot state enum and the slot length helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1100111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Cycles per digit slot.
    function automatic int slot_len(input int clk_hz, input int refresh_hz);
        return clk_hz / refresh_hz;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Ports: bcd (4-bit digit), blank (force all segments off), seg ({g..a}).
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_OFF;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with dead-time blanking and a
// double-buffered value behind a load/ack handshake.
// Ports: i_clk, i_rst (async high); i_value/i_load/i_lzb in;
//        o_seg, o_sel, o_pending, o_ack, o_frame out (all registered).
module seg_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int REFRESH_HZ   = 90,
    parameter int BLANK_CYCLES = 2700,
    parameter int NUM_DIGITS   = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic                      i_load,
    input  logic                      i_lzb,
    output logic [6:0]                o_seg,
    output logic [NUM_DIGITS-1:0]     o_sel,
    output logic                      o_pending,
    output logic                      o_ack,
    output logic                      o_frame
);

    localparam int SLOT = slot_len(CLK_HZ, REFRESH_HZ);
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ND   = NUM_DIGITS;
    localparam logic [6:0] SEG_IDLE =
        (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    scan_state_t         state, n_state;
    logic [CW-1:0]       cnt, n_cnt;
    logic [IW-1:0]       idx, n_idx;
    logic [4*ND-1:0]     active, shadow, n_active;
    logic                run, lzb_q, lzb_eff;
    logic                wrap, frame, commit;
    logic [3:0]          nib;
    logic                zero_hi;
    logic [ND:0]         zf;
    logic                blank;
    logic [6:0]          pat;
    logic [ND-1:0]       sel_nx;

    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_idx   = idx;
        wrap    = 1'b0;
        frame   = 1'b0;
        // The first edge after reset only loads the outputs, so the
        // opening slot is shown for its full length.
        if (run) begin
            n_cnt = (cnt == CW'(SLOT - 1)) ? '0 : cnt + 1'b1;
            if (state == SHOW && cnt == CW'(SLOT - BLANK_CYCLES - 1)
                && BLANK_CYCLES != 0) begin
                n_state = BLANK;
            end
            if (cnt == CW'(SLOT - 1)) begin
                n_state = SHOW;
                wrap    = 1'b1;
                frame   = (idx == IW'(ND - 1));
                n_idx   = frame ? '0 : idx + 1'b1;
            end
        end
    end

    assign commit   = frame && o_pending;
    assign n_active = commit ? shadow : active;
    assign lzb_eff  = (wrap || !run) ? i_lzb : lzb_q;

    // Digit k is a leading zero when it and every higher digit are zero.
    always_comb begin
        zf[ND]  = 1'b1;
        nib     = '0;
        zero_hi = 1'b0;
        for (int k = ND - 1; k >= 0; k--) begin
            zf[k] = zf[k+1] && (n_active[4*k +: 4] == 4'd0);
        end
        for (int k = 0; k < ND; k++) begin
            if (n_idx == IW'(k)) begin
                nib     = n_active[4*k +: 4];
                zero_hi = zf[k];
            end
        end
    end

    assign blank  = (n_state == BLANK) ||
                    (lzb_eff && n_idx != '0 && zero_hi);
    assign sel_nx = (n_state == SHOW) ? (ND'(1) << n_idx) : '0;

    bcd_to_seg7 u_dec (
        .bcd   (nib),
        .blank (blank),
        .seg   (pat)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= SHOW;
            cnt       <= '0;
            idx       <= '0;
            active    <= '0;
            shadow    <= '0;
            run       <= 1'b0;
            lzb_q     <= 1'b0;
            o_seg     <= SEG_IDLE;
            o_sel     <= '0;
            o_pending <= 1'b0;
            o_ack     <= 1'b0;
            o_frame   <= 1'b0;
        end else begin
            run     <= 1'b1;
            state   <= n_state;
            cnt     <= n_cnt;
            idx     <= n_idx;
            active  <= n_active;
            lzb_q   <= lzb_eff;
            o_sel   <= sel_nx;
            o_seg   <= (ACTIVE_LOW != 0) ? ~pat : pat;
            o_ack   <= commit;
            o_frame <= frame;
            if (i_load) begin
                shadow    <= i_value;
                o_pending <= 1'b1;
            end else if (commit) begin
                o_pending <= 1'b0;
            end
        end
    end

endmodule
